// File: rtl/snow64_decode_issue_controller_pkg.sv
// Shared types and constants for the Snow64 decode/issue sequencer and the
// instruction decoder it feeds.
package snow64_decode_issue_controller_pkg;

    localparam int WIDTH__INSTR = 32;

    // 2-bit stall-type encoding produced by the decoder.
    localparam logic [1:0] STALL_NONE       = 2'd0;
    localparam logic [1:0] STALL_ENDS_IN_EX = 2'd1;
    localparam logic [1:0] STALL_ENDS_IN_WB = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_HELD    = 2'd1,
        ST_WAIT_EX = 2'd2,
        ST_WAIT_WB = 2'd3
    } state_dec_issue_t;

endpackage

// File: rtl/snow64_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module snow64_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/snow64_decode_issue_controller.sv
// Decode-stage sequencer: holds one instruction for the decoder, issues it over
// valid/ready and blocks until its EX/WB completion. Optional perf counters
// under SNOW64_DECODE_ISSUE_PERF_CNT_EN.
module snow64_decode_issue_controller
    import snow64_decode_issue_controller_pkg::*;
#(
    parameter int WIDTH__INSTR    = snow64_decode_issue_controller_pkg::WIDTH__INSTR,
    parameter int WIDTH__PERF_CNT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH__INSTR-1:0] in_instr,
    output logic                    in_ready,
    output logic [WIDTH__INSTR-1:0] dec_instr,
    input  logic                    dec_nop,
    input  logic [1:0]              dec_stall_type,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    ex_done,
    input  logic                    wb_done,
    input  logic                    flush,
    output logic                    busy
`ifdef SNOW64_DECODE_ISSUE_PERF_CNT_EN
    ,
    output logic [WIDTH__PERF_CNT-1:0] perf_issued,
    output logic [WIDTH__PERF_CNT-1:0] perf_nops,
    output logic [WIDTH__PERF_CNT-1:0] perf_stall_cycles
`endif
);

    state_dec_issue_t state, state_next;
    logic             accept;
    logic             live;

    // live keeps the handshakes closed while reset is asserted and opens them
    // from the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            dec_instr <= '0;
            live      <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
            if (accept) begin
                dec_instr <= in_instr;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else if (live) begin
            case (state)
                ST_EMPTY: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (dec_nop) begin
                        in_ready   = 1'b1;
                        accept     = in_valid;
                        state_next = in_valid ? ST_HELD : ST_EMPTY;
                    end else begin
                        out_valid = 1'b1;
                        in_ready  = out_ready && (dec_stall_type == STALL_NONE);
                        if (out_ready) begin
                            case (dec_stall_type)
                                STALL_NONE: begin
                                    accept     = in_valid;
                                    state_next = in_valid ? ST_HELD : ST_EMPTY;
                                end
                                STALL_ENDS_IN_EX: state_next = ST_WAIT_EX;
                                default:          state_next = ST_WAIT_WB;
                            endcase
                        end
                    end
                end
                // A done pulse in the fire cycle is seen in HELD and ignored.
                ST_WAIT_EX: if (ex_done) state_next = ST_EMPTY;
                ST_WAIT_WB: if (wb_done) state_next = ST_EMPTY;
                default:    state_next = ST_EMPTY;
            endcase
        end
    end

    assign busy = (state != ST_EMPTY);

`ifdef SNOW64_DECODE_ISSUE_PERF_CNT_EN
    logic inc_issued, inc_nop, inc_stall;

    assign inc_issued = out_valid && out_ready;
    assign inc_nop    = live && !flush && (state == ST_HELD) && dec_nop;
    assign inc_stall  = (state == ST_WAIT_EX) || (state == ST_WAIT_WB);

    snow64_sat_counter #(.WIDTH(WIDTH__PERF_CNT)) u_cnt_issued (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_issued),
        .count (perf_issued)
    );

    snow64_sat_counter #(.WIDTH(WIDTH__PERF_CNT)) u_cnt_nops (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_nop),
        .count (perf_nops)
    );

    snow64_sat_counter #(.WIDTH(WIDTH__PERF_CNT)) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_stall),
        .count (perf_stall_cycles)
    );
`endif

endmodule
